// File: rtl/dm_arb_pkg.sv
// dm_arbiter shared definitions: requester ids, lock states,
// alignment helper.
package dm_arb_pkg;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  localparam int ALIGN_W = 2;

  typedef enum logic [1:0] {
    FREE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } lock_st_t;

  function automatic logic is_aligned(input logic [31:0] a);
    return a[ALIGN_W-1:0] == '0;
  endfunction

endpackage

// File: rtl/dm_arbiter_rr_pick.sv
// Two-way round-robin picker; a set mask bit blocks that requester.
// Output grant is one-hot or zero.
module dm_rr_pick
  import dm_arb_pkg::*;
(
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_prio,
  input  logic [1:0] i_mask,
  output logic [1:0] o_gnt
);

  logic w_r0;
  logic w_r1;

  assign w_r0 = i_req0 & ~i_mask[0];
  assign w_r1 = i_req1 & ~i_mask[1];

  assign o_gnt[0] = w_r0 & (~w_r1 | (i_prio == M0));
  assign o_gnt[1] = w_r1 & (~w_r0 | (i_prio == M1));

endmodule

// File: rtl/dm_arbiter.sv
// Round-robin data-memory arbiter for MEM stage (m0) and debug port (m1).
// Optional ownership locking is built when DM_ARB_LOCK_EN is defined.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int IDX_W    = 10,
  parameter int LOCK_MAX = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             m0_req,
  input  logic             m1_req,
  input  logic             m0_we,
  input  logic             m1_we,
  input  logic [31:0]      m0_addr,
  input  logic [31:0]      m1_addr,
  input  logic [31:0]      m0_wdata,
  input  logic [31:0]      m1_wdata,
  input  logic             m0_lock,
  input  logic             m1_lock,
  output logic             m0_gnt,
  output logic             m1_gnt,
  output logic             m0_rvalid,
  output logic             m1_rvalid,
  output logic             m0_err,
  output logic             m1_err,
  output logic [31:0]      m_rdata,
  output logic             dm_we,
  output logic [31:0]      dm_addr,
  output logic [IDX_W-1:0] dm_a,
  output logic [31:0]      dm_wd,
  input  logic [31:0]      dm_rd
);

  logic        r_prio;
  logic        r_rv0;
  logic        r_rv1;
  logic        r_er0;
  logic        r_er1;
  logic [31:0] r_rdata;

  logic [1:0]  w_mask;
  logic [1:0]  w_pick;
  logic        w_g0;
  logic        w_g1;
  logic        w_any;
  logic        w_we;
  logic        w_al;

  dm_rr_pick u_pick (
    .i_req0 (m0_req),
    .i_req1 (m1_req),
    .i_prio (r_prio),
    .i_mask (w_mask),
    .o_gnt  (w_pick)
  );

  assign w_g0  = w_pick[0] & ~reset;
  assign w_g1  = w_pick[1] & ~reset;
  assign w_any = w_g0 | w_g1;

  assign dm_addr = w_g1 ? m1_addr  : m0_addr;
  assign dm_wd   = w_g1 ? m1_wdata : m0_wdata;
  assign w_we    = w_g1 ? m1_we    : m0_we;
  assign dm_a    = dm_addr[IDX_W+1:2];
  assign w_al    = is_aligned(dm_addr);
  assign dm_we   = w_any & w_we & w_al;

  assign m0_gnt = w_g0;
  assign m1_gnt = w_g1;

  // Reset cancels a response that is already sitting in the registers.
  assign m0_rvalid = r_rv0 & ~reset;
  assign m1_rvalid = r_rv1 & ~reset;
  assign m0_err    = r_er0 & ~reset;
  assign m1_err    = r_er1 & ~reset;
  assign m_rdata   = r_rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio  <= M0;
      r_rv0   <= 1'b0;
      r_rv1   <= 1'b0;
      r_er0   <= 1'b0;
      r_er1   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_rv0 <= w_g0;
      r_rv1 <= w_g1;
      r_er0 <= w_g0 & ~w_al;
      r_er1 <= w_g1 & ~w_al;
      if (w_any) begin
        r_prio <= w_g1 ? M0 : M1;
        if (!w_al)
          r_rdata <= '0;
        else if (!w_we)
          r_rdata <= dm_rd;
      end
    end
  end

`ifdef DM_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam logic [CW-1:0] LMAX = CW'(LOCK_MAX);

  lock_st_t      r_st;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nx;

  assign w_cnt_nx = r_cnt + CW'(1);

  always_comb begin
    w_mask = 2'b00;
    unique case (1'b1)
      (r_st == OWN0): w_mask = 2'b10;
      (r_st == OWN1): w_mask = 2'b01;
      default:        w_mask = 2'b00;
    endcase
  end

  // Hitting LOCK_MAX coincides with a grant, so prio already
  // points at the other requester when the lock is broken.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_st  <= FREE;
      r_cnt <= '0;
    end else begin
      unique case (r_st)
        FREE: begin
          if (w_g0 && m0_lock) begin
            r_st  <= OWN0;
            r_cnt <= CW'(1);
          end else if (w_g1 && m1_lock) begin
            r_st  <= OWN1;
            r_cnt <= CW'(1);
          end
        end
        OWN0: begin
          if (!m0_req) begin
            r_st  <= FREE;
            r_cnt <= '0;
          end else if (w_g0) begin
            if (!m0_lock || w_cnt_nx == LMAX) begin
              r_st  <= FREE;
              r_cnt <= '0;
            end else begin
              r_cnt <= w_cnt_nx;
            end
          end
        end
        OWN1: begin
          if (!m1_req) begin
            r_st  <= FREE;
            r_cnt <= '0;
          end else if (w_g1) begin
            if (!m1_lock || w_cnt_nx == LMAX) begin
              r_st  <= FREE;
              r_cnt <= '0;
            end else begin
              r_cnt <= w_cnt_nx;
            end
          end
        end
        default: begin
          r_st  <= FREE;
          r_cnt <= '0;
        end
      endcase
    end
  end
`else
  logic w_unused;
  assign w_unused = &{1'b0, m0_lock, m1_lock};
  assign w_mask   = 2'b00;
`endif

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a behavioural
// 1024x32 memory; the lock test runs only with DM_ARB_LOCK_EN.
module tb_dm_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m1_req;
  logic        m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_lock, m1_lock;
  logic        m0_gnt, m1_gnt;
  logic        m0_rvalid, m1_rvalid;
  logic        m0_err, m1_err;
  logic [31:0] m_rdata;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [9:0]  dm_a;
  logic [31:0] dm_wd;
  logic [31:0] dm_rd;

  logic [31:0] mem [0:1023];

  int n_assert = 0;
  int n_fail   = 0;

  dm_arbiter #(.IDX_W(10), .LOCK_MAX(16)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m1_req    (m1_req),
    .m0_we     (m0_we),
    .m1_we     (m1_we),
    .m0_addr   (m0_addr),
    .m1_addr   (m1_addr),
    .m0_wdata  (m0_wdata),
    .m1_wdata  (m1_wdata),
    .m0_lock   (m0_lock),
    .m1_lock   (m1_lock),
    .m0_gnt    (m0_gnt),
    .m1_gnt    (m1_gnt),
    .m0_rvalid (m0_rvalid),
    .m1_rvalid (m1_rvalid),
    .m0_err    (m0_err),
    .m1_err    (m1_err),
    .m_rdata   (m_rdata),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_a      (dm_a),
    .dm_wd     (dm_wd),
    .dm_rd     (dm_rd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dm_rd = mem[dm_a];
  always @(posedge clk) if (dm_we) mem[dm_a] <= dm_wd;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m0_req = 0; m1_req = 0;
    m0_we = 0;  m1_we = 0;
    m0_lock = 0; m1_lock = 0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    reset = 1;
    idle();
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    tick();
    tick();
    // reset state and reset dominating a request
    m0_req = 1; m0_we = 1; m0_addr = 32'h10; m0_wdata = 32'h5555_5555;
    #1;
    chk("rst_gnt0", {31'b0, m0_gnt}, 0);
    chk("rst_dmwe", {31'b0, dm_we}, 0);
    chk("rst_rv0", {31'b0, m0_rvalid}, 0);
    chk("rst_rv1", {31'b0, m1_rvalid}, 0);
    chk("rst_rdata", m_rdata, 0);
    tick();
    chk("rst_mem4", mem[4], 0);
    reset = 0;

    // m0 write 0x12345678 to 0x10
    m0_wdata = 32'h1234_5678;
    #1;
    chk("wr_gnt0", {31'b0, m0_gnt}, 1);
    chk("wr_dmwe", {31'b0, dm_we}, 1);
    chk("wr_dma", {22'b0, dm_a}, 4);
    tick();
    idle();
    #1;
    chk("wr_rv0", {31'b0, m0_rvalid}, 1);
    chk("wr_err0", {31'b0, m0_err}, 0);
    chk("wr_rv1", {31'b0, m1_rvalid}, 0);
    chk("wr_rdata", m_rdata, 0);
    // m1 reads back 0x10
    m1_req = 1; m1_addr = 32'h10;
    #1;
    chk("rb_gnt1", {31'b0, m1_gnt}, 1);
    tick();
    idle();
    #1;
    chk("rb_rv1", {31'b0, m1_rvalid}, 1);
    chk("rb_rdata", m_rdata, 32'h1234_5678);

    // alternating reads, prio now m0
    mem[8] = 32'hA0A0_0008;
    mem[9] = 32'hB0B0_0009;
    m0_req = 1; m0_addr = 32'h20;
    m1_req = 1; m1_addr = 32'h24;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("alt_gnt0", {31'b0, m0_gnt}, (k % 2 == 0) ? 1 : 0);
      chk("alt_gnt1", {31'b0, m1_gnt}, (k % 2 == 1) ? 1 : 0);
      tick();
      chk("alt_rv0", {31'b0, m0_rvalid}, (k % 2 == 0) ? 1 : 0);
      chk("alt_rv1", {31'b0, m1_rvalid}, (k % 2 == 1) ? 1 : 0);
      chk("alt_rdata", m_rdata,
          (k % 2 == 0) ? 32'hA0A0_0008 : 32'hB0B0_0009);
    end
    idle();

    // misaligned m1 write to 0x6, prio now m0
    m1_req = 1; m1_we = 1; m1_addr = 32'h6; m1_wdata = 32'hDEAD_BEEF;
    #1;
    chk("mis_gnt1", {31'b0, m1_gnt}, 1);
    chk("mis_dmwe", {31'b0, dm_we}, 0);
    tick();
    idle();
    #1;
    chk("mis_rv1", {31'b0, m1_rvalid}, 1);
    chk("mis_err1", {31'b0, m1_err}, 1);
    chk("mis_rv0", {31'b0, m0_rvalid}, 0);
    chk("mis_rdata", m_rdata, 0);
    chk("mis_mem1", mem[1], 0);
    chk("mis_mem0", mem[0], 0);

    // m0 read granted, then reset; prio would otherwise be m1
    m0_req = 1; m0_addr = 32'h20;
    #1;
    chk("rr_gnt0", {31'b0, m0_gnt}, 1);
    tick();
    idle();
    reset = 1;
    #1;
    chk("rr_rv0_cancel", {31'b0, m0_rvalid}, 0);
    tick();
    chk("rr_rv0", {31'b0, m0_rvalid}, 0);
    chk("rr_rdata", m_rdata, 0);
    reset = 0;
    m0_req = 1; m0_addr = 32'h20;
    m1_req = 1; m1_addr = 32'h24;
    #1;
    chk("rr_prio_g0", {31'b0, m0_gnt}, 1);
    chk("rr_prio_g1", {31'b0, m1_gnt}, 0);
    tick();
    idle();
    chk("rr_after_rd", m_rdata, 32'hA0A0_0008);

    // alias: 0x1008 maps to word 2, prio now m1
    m0_req = 1; m0_we = 1; m0_addr = 32'h0000_1008; m0_wdata = 32'hCAFE_F00D;
    #1;
    chk("al_dma", {22'b0, dm_a}, 2);
    chk("al_dmwe", {31'b0, dm_we}, 1);
    chk("al_dmaddr", dm_addr, 32'h0000_1008);
    tick();
    idle();
    m1_req = 1; m1_addr = 32'h8;
    #1;
    chk("al_gnt1", {31'b0, m1_gnt}, 1);
    tick();
    idle();
    chk("al_rdata", m_rdata, 32'hCAFE_F00D);
    chk("al_mem2", mem[2], 32'hCAFE_F00D);

`ifdef DM_ARB_LOCK_EN
    // m0 locks; prio is m0 after the m1 read above
    m0_req = 1; m0_lock = 1; m0_addr = 32'h20;
    m1_req = 1; m1_addr = 32'h24;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("lk_gnt0", {31'b0, m0_gnt}, 1);
      chk("lk_gnt1", {31'b0, m1_gnt}, 0);
      tick();
    end
    #1;
    chk("lk_brk_g1", {31'b0, m1_gnt}, 1);
    chk("lk_brk_g0", {31'b0, m0_gnt}, 0);
    tick();
    idle();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/dm_arbiter.md
Name: dm_arbiter

Overview:
- Shares the single-port data memory (1024 x 32-bit words, write on the clock edge, combinational read) between two requesters: m0 (pipeline MEM stage) and m1 (debug/loader port).
- Arbitrates round-robin with a valid/grant handshake.
- Drives the memory's write enable, full byte address, word index and write data.
- Registers read data and returns it one cycle after grant.

Parameters:
- IDX_W, 10, word-index width; the memory holds 2**IDX_W words.
- LOCK_MAX, 16, maximum consecutive locked grants before the lock is forcibly broken (used only with DM_ARB_LOCK_EN).

Ports:
- clk  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- m0_req, m1_req  in  1  access request; held with its fields until granted
- m0_we, m1_we  in  1  1 = write, 0 = read
- m0_addr, m1_addr  in  32  byte address
- m0_wdata, m1_wdata  in  32  write data
- m0_lock, m1_lock  in  1  hold ownership after this transfer (DM_ARB_LOCK_EN only)
- m0_gnt, m1_gnt  out  1  combinational; transfer accepted this cycle
- m0_rvalid, m1_rvalid  out  1  registered; response valid one cycle after grant
- m0_err, m1_err  out  1  registered; qualifies rvalid for a misaligned access
- m_rdata  out  32  registered read data, shared by both requesters and qualified by mX_rvalid
- dm_we  out  1  memory write enable
- dm_addr  out  32  byte address of the granted requester (used by the memory's write log)
- dm_a  out  IDX_W  word index, equal to dm_addr[IDX_W+1:2]
- dm_wd  out  32  memory write data
- dm_rd  in  32  memory combinational read data

Behaviour:
- At most one grant per cycle. A grant is issued in the same cycle as the request and completes the handshake.
- Arbitration:
  - A lone request is always granted.
  - When both request, the requester named by the priority pointer prio wins.
  - After any grant, prio points to the other requester (round-robin).
  - The loser waits at most one cycle.
- Downstream outputs:
  - dm_addr, dm_a and dm_wd are driven from the winner; when nobody is granted they are driven from m0.
  - dm_we = granted & we & aligned.
- Alignment: an access is aligned when addr[1:0] == 0. Address bits above IDX_W+1 are ignored and alias.
- Write timing: memory updates at the edge ending the grant cycle. The next cycle sees rvalid = 1 and m_rdata unchanged.
- Read timing: dm_rd is sampled at the edge ending the grant cycle. The next cycle sees m_rdata = that word and the winner's rvalid = 1.
  - Back-to-back reads from either requester are supported at full rate.
- Misaligned access: granted and handshake completed, but no memory write. Next cycle: rvalid = 1, err = 1, m_rdata = 0.
- rvalid and err are single-cycle pulses. The non-winner's rvalid and err are 0.
- Reset: prio = m0, all rvalid/err = 0, m_rdata = 0, lock state = FREE, lock counter = 0.
  - Reset dominates a concurrent request: no grant, dm_we = 0.
  - A response pending from the previous cycle is cancelled (rvalid = 0).

Optional Feature:
- Macro: DM_ARB_LOCK_EN.
- With the macro: state machine FREE / OWN0 / OWN1.
  - FREE -> OWNx when mx is granted with mx_lock = 1; the counter loads 1.
  - In OWNx only mx may be granted; the other requester is blocked.
  - Each locked grant increments the counter.
  - Return to FREE when a grant has mx_lock = 0, when mx_req = 0 for a cycle, or when the counter reaches LOCK_MAX. A forced exit sets prio to the other requester.
  - Reset returns to FREE.
- Without the macro: lock inputs ignored, no state machine, pure round-robin.

Decomposition:
- Package dm_arb_pkg: requester id constants (M0 = 0, M1 = 1), lock state encoding (FREE, OWN0, OWN1) and the alignment check width.
- One natural sub-module, dm_rr_pick: the 2-way round-robin picker. Inputs are the two requests, prio and a lock mask; outputs are the one-hot grant.
- Response registers and the lock state machine stay in dm_arbiter.

Test Plan:
- Reset, then m0 writes 0x1234_5678 to 0x0000_0010 → m0_gnt = 1 same cycle, dm_we = 1, dm_a = 4; m0_rvalid = 1 next cycle; an m1 read of 0x10 afterwards returns 0x1234_5678.
- m0 and m1 request reads every cycle for 6 cycles → grants alternate m0, m1, m0, …; each rvalid follows its grant by exactly one cycle with the correct data.
- m1 writes to 0x0000_0006 (misaligned) → m1_gnt = 1, dm_we = 0, next cycle m1_err = 1, m_rdata = 0; memory unchanged.
- m0 read granted, reset asserted on the following edge → m0_rvalid stays 0, prio = m0, m_rdata = 0.
- Address 0x0000_1008 → dm_a = 2, and the access aliases with 0x0000_0008.
- With DM_ARB_LOCK_EN: m0 requests continuously with lock = 1 while m1 requests → m1 is blocked for exactly LOCK_MAX = 16 grants, then granted the next cycle.
